// File: rtl/mips_enc_pkg.sv
// rtl/mips_enc_pkg.sv - shared instruction kinds, MIPS opcode/funct values, encoder FSM states and field packing helpers
package mips_enc_pkg;

    typedef enum logic [4:0] {
        KIND_ADD   = 5'd0,
        KIND_ADDU  = 5'd1,
        KIND_SUB   = 5'd2,
        KIND_SUBU  = 5'd3,
        KIND_AND   = 5'd4,
        KIND_OR    = 5'd5,
        KIND_SLT   = 5'd6,
        KIND_ADDI  = 5'd7,
        KIND_ADDIU = 5'd8,
        KIND_ANDI  = 5'd9,
        KIND_ORI   = 5'd10,
        KIND_LUI   = 5'd11,
        KIND_BEQ   = 5'd12,
        KIND_BNE   = 5'd13,
        KIND_LW    = 5'd14,
        KIND_SW    = 5'd15,
        KIND_J     = 5'd16
    } kind_e;

    // Opcode values shared with the decoder's opcode table.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_FULL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_field_packer.sv
// rtl/mips_field_packer.sv - combinational descriptor to 32-bit MIPS word packer with kind validity flag
module mips_field_packer
    import mips_enc_pkg::*;
(
    input  logic [4:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        kind_valid
);

    always_comb begin
        word       = '0;
        kind_valid = 1'b1;
        case (kind)
            KIND_ADD:   word = pack_r(rs, rt, rd, FN_ADD);
            KIND_ADDU:  word = pack_r(rs, rt, rd, FN_ADDU);
            KIND_SUB:   word = pack_r(rs, rt, rd, FN_SUB);
            KIND_SUBU:  word = pack_r(rs, rt, rd, FN_SUBU);
            KIND_AND:   word = pack_r(rs, rt, rd, FN_AND);
            KIND_OR:    word = pack_r(rs, rt, rd, FN_OR);
            KIND_SLT:   word = pack_r(rs, rt, rd, FN_SLT);
            KIND_ADDI:  word = pack_i(OP_ADDI, rs, rt, imm);
            KIND_ADDIU: word = pack_i(OP_ADDIU, rs, rt, imm);
            KIND_ANDI:  word = pack_i(OP_ANDI, rs, rt, imm);
            KIND_ORI:   word = pack_i(OP_ORI, rs, rt, imm);
            // LUI has no source register; rs is forced to zero.
            KIND_LUI:   word = pack_i(OP_LUI, 5'd0, rt, imm);
            KIND_BEQ:   word = pack_i(OP_BEQ, rs, rt, imm);
            KIND_BNE:   word = pack_i(OP_BNE, rs, rt, imm);
            KIND_LW:    word = pack_i(OP_LW, rs, rt, imm);
            KIND_SW:    word = pack_i(OP_SW, rs, rt, imm);
            KIND_J:     word = {OP_J, target};
            default:    kind_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - descriptor encoder and sequential imem writer; optional halt stub under ENC_HALT_STUB_EN
module mips_instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              seal,
    output logic              imem_we,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              inv_op,
    output logic              full,
    output logic              sealed
);

    localparam logic [ADDR_W:0] WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       wdata_q;
    logic              inv_q;
    logic              stub_q;
    logic [31:0]       enc_word;
    logic              enc_valid;
    logic [ADDR_W:0]   count_inc;
    logic [25:0]       stub_target;
    logic              seal_req;

    mips_field_packer u_packer (
        .kind       (in_kind),
        .rs         (in_rs),
        .rt         (in_rt),
        .rd         (in_rd),
        .imm        (in_imm),
        .target     (in_target),
        .word       (enc_word),
        .kind_valid (enc_valid)
    );

    assign count_inc   = count_q + ONE;
    // Halt stub jumps to its own address, giving the core a tight spin loop.
    assign stub_target = 26'(BASE_ADDR) + 26'(count_q);

`ifdef ENC_HALT_STUB_EN
    assign seal_req = seal;
    assign sealed   = (state == ST_DONE);
`else
    logic unused_seal;
    assign seal_req    = 1'b0;
    assign sealed      = 1'b0;
    assign unused_seal = seal;
`endif

    assign in_ready   = (state == ST_IDLE);
    assign imem_we    = (state == ST_WR);
    assign full       = (state == ST_FULL);
    assign imem_addr  = count_q[ADDR_W-1:0];
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign inv_op     = inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count_q <= '0;
            wdata_q <= '0;
            inv_q   <= 1'b0;
            stub_q  <= 1'b0;
        end else begin
            inv_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A descriptor takes precedence; a held seal is served once the input goes quiet.
                    if (in_valid) begin
                        if (enc_valid) begin
                            wdata_q <= enc_word;
                            stub_q  <= 1'b0;
                            state   <= ST_WR;
                        end else begin
                            inv_q <= 1'b1;
                        end
                    end else if (seal_req) begin
                        wdata_q <= {OP_J, stub_target};
                        stub_q  <= 1'b1;
                        state   <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (imem_ack) begin
                        count_q <= count_inc;
                        if (stub_q) begin
                            state <= ST_DONE;
                        end else if (count_inc == WORDS) begin
                            state <= ST_FULL;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_FULL: state <= ST_FULL;
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - self-checking bench for mips_instr_encoder with a behavioural encoding model
module tb_mips_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, seal, imem_ack;
    logic [4:0]  in_kind, in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_ready, imem_we, inv_op, full, sealed;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] count;

    logic        rst_b, valid_b, ack_b;
    logic        b_ready, b_we, b_inv, b_full, b_sealed;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;

    int checks = 0;
    int errors = 0;

    mips_instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .seal(seal),
        .imem_we(imem_we), .imem_ack(imem_ack), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .inv_op(inv_op),
        .full(full), .sealed(sealed)
    );

    mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst(rst_b), .in_valid(valid_b), .in_ready(b_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .seal(1'b0),
        .imem_we(b_we), .imem_ack(ack_b), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .count(b_count), .inv_op(b_inv),
        .full(b_full), .sealed(b_sealed)
    );

    // Reference encoding from the instruction-set tables: bit 32 = kind valid.
    function automatic logic [32:0] ref_enc(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [15:0] imm,
                                            input logic [25:0] tgt);
        logic [5:0] op;
        if (k >= 0 && k <= 6)
            return {1'b1, 6'd0, rs, rt, rd, 5'd0, (k == 6) ? 6'h2A : 6'(32 + k)};
        case (k)
            7:  op = 6'h08;
            8:  op = 6'h09;
            9:  op = 6'h0C;
            10: op = 6'h0D;
            11: op = 6'h0F;
            12: op = 6'h04;
            13: op = 6'h05;
            14: op = 6'h23;
            15: op = 6'h2B;
            16: return {1'b1, 6'h02, tgt};
            default: return 33'd0;
        endcase
        return {1'b1, op, (k == 11) ? 5'd0 : rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_desc(input int k, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        in_kind = 5'(k); in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1; in_valid = 1'b0; valid_b = 1'b0; seal = 1'b0;
        imem_ack = 1'b0; ack_b = 1'b0;
        set_desc(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checks++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, count, inv_op, full, sealed} !==
            {1'b1, 1'b0, 10'd0, 32'd0, 11'd0, 3'b000})
            begin errors++; $display("FAIL reset_a got %h exp %h",
                {in_ready, imem_we, imem_addr, imem_wdata, count, inv_op, full, sealed},
                {1'b1, 1'b0, 10'd0, 32'd0, 11'd0, 3'b000}); end
        checks++;
        if ({b_ready, b_we, b_addr, b_wdata, b_count, b_inv, b_full, b_sealed} !==
            {1'b1, 1'b0, 2'd0, 32'd0, 3'd0, 3'b000})
            begin errors++; $display("FAIL reset_b got %h exp %h",
                {b_ready, b_we, b_addr, b_wdata, b_count, b_inv, b_full, b_sealed},
                {1'b1, 1'b0, 2'd0, 32'd0, 3'd0, 3'b000}); end
        rst = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_add();
        do_reset();
        imem_ack = 1'b1;
        set_desc(0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, in_ready, count} !== {1'b1, 10'd0, 32'h00221820, 1'b0, 11'd0})
            begin errors++; $display("FAIL add_write got %h exp %h",
                {imem_we, imem_addr, imem_wdata, in_ready, count}, {1'b1, 10'd0, 32'h00221820, 1'b0, 11'd0}); end
        tick();
        checks++;
        if ({imem_we, in_ready, count} !== {1'b0, 1'b1, 11'd1})
            begin errors++; $display("FAIL add_after got %h exp %h", {imem_we, in_ready, count}, {1'b0, 1'b1, 11'd1}); end
        imem_ack = 1'b0;
    endtask

    task automatic test_two_words();
        do_reset();
        imem_ack = 1'b1;
        set_desc(7, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h20080005})
            begin errors++; $display("FAIL addi_word got %h exp %h", {imem_we, imem_addr, imem_wdata}, {1'b1, 10'd0, 32'h20080005}); end
        tick();
        set_desc(14, 5'd29, 5'd4, 5'd0, 16'hFFFC, 26'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd1, 32'h8FA4FFFC})
            begin errors++; $display("FAIL lw_word got %h exp %h", {imem_we, imem_addr, imem_wdata}, {1'b1, 10'd1, 32'h8FA4FFFC}); end
        tick();
        checks++;
        if (count !== 11'd2) begin errors++; $display("FAIL two_count got %0d exp 2", count); end
        imem_ack = 1'b0;
    endtask

    task automatic test_ack_delay();
        do_reset();
        imem_ack = 1'b0;
        set_desc(0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) imem_ack = 1'b1;
            checks++;
            if ({imem_we, imem_addr, imem_wdata, in_ready, count} !== {1'b1, 10'd0, 32'h00221820, 1'b0, 11'd0})
                begin errors++; $display("FAIL delay_hold%0d got %h exp %h", i,
                    {imem_we, imem_addr, imem_wdata, in_ready, count}, {1'b1, 10'd0, 32'h00221820, 1'b0, 11'd0}); end
            tick();
        end
        imem_ack = 1'b0;
        checks++;
        if ({imem_we, in_ready, count} !== {1'b0, 1'b1, 11'd1})
            begin errors++; $display("FAIL delay_after got %h exp %h", {imem_we, in_ready, count}, {1'b0, 1'b1, 11'd1}); end
    endtask

    task automatic test_invalid();
        do_reset();
        set_desc(31, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({inv_op, imem_we, in_ready, count} !== {1'b1, 1'b0, 1'b1, 11'd0})
            begin errors++; $display("FAIL inv_pulse got %h exp %h", {inv_op, imem_we, in_ready, count}, {1'b1, 1'b0, 1'b1, 11'd0}); end
        tick();
        checks++;
        if ({inv_op, imem_we} !== 2'b00)
            begin errors++; $display("FAIL inv_end got %b exp 00", {inv_op, imem_we}); end
        imem_ack = 1'b1;
        set_desc(0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h00221820})
            begin errors++; $display("FAIL inv_next got %h exp %h", {imem_we, imem_addr, imem_wdata}, {1'b1, 10'd0, 32'h00221820}); end
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_random();
        int k, dly, gap, exp_count;
        logic hold;
        logic [32:0] r;
        do_reset();
        exp_count = 0;
        for (int n = 0; n < 60; n++) begin
            k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
            set_desc(k, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
            r = ref_enc(k, in_rs, in_rt, in_rd, in_imm, in_target);
            in_valid = 1'b1;
            tick();
            if (r[32]) begin
                hold = 1'($urandom_range(0, 1));
                if (!hold) in_valid = 1'b0;
                dly = $urandom_range(0, 3);
                for (int d = 0; d <= dly; d++) begin
                    imem_ack = (d == dly);
                    checks++;
                    if ({imem_we, imem_addr, imem_wdata, in_ready, count} !==
                        {1'b1, 10'(exp_count), r[31:0], 1'b0, 11'(exp_count)})
                        begin errors++; $display("FAIL rand_wr n%0d kind%0d got %h exp %h", n, k,
                            {imem_we, imem_addr, imem_wdata, in_ready, count},
                            {1'b1, 10'(exp_count), r[31:0], 1'b0, 11'(exp_count)}); end
                    tick();
                end
                exp_count++;
                in_valid = 1'b0;
                imem_ack = 1'b0;
                checks++;
                if ({imem_we, in_ready, count, inv_op} !== {1'b0, 1'b1, 11'(exp_count), 1'b0})
                    begin errors++; $display("FAIL rand_ack n%0d got %h exp %h", n,
                        {imem_we, in_ready, count, inv_op}, {1'b0, 1'b1, 11'(exp_count), 1'b0}); end
            end else begin
                in_valid = 1'b0;
                checks++;
                if ({inv_op, imem_we, in_ready, count} !== {1'b1, 1'b0, 1'b1, 11'(exp_count)})
                    begin errors++; $display("FAIL rand_inv n%0d kind%0d got %h exp %h", n, k,
                        {inv_op, imem_we, in_ready, count}, {1'b1, 1'b0, 1'b1, 11'(exp_count)}); end
                tick();
                checks++;
                if (inv_op !== 1'b0) begin errors++; $display("FAIL rand_inv_end n%0d got %b exp 0", n, inv_op); end
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic test_full();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        ack_b = 1'b1;
        set_desc(0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        for (int i = 0; i < 4; i++) begin
            valid_b = 1'b1;
            tick();
            valid_b = 1'b0;
            checks++;
            if ({b_we, b_addr, b_wdata} !== {1'b1, 2'(i), 32'h00221820})
                begin errors++; $display("FAIL full_wr%0d got %h exp %h", i, {b_we, b_addr, b_wdata}, {1'b1, 2'(i), 32'h00221820}); end
            tick();
            checks++;
            if ({b_count, b_full, b_ready} !== {3'(i + 1), (i == 3), (i != 3)})
                begin errors++; $display("FAIL full_state%0d got %b exp %b", i,
                    {b_count, b_full, b_ready}, {3'(i + 1), (i == 3), (i != 3)}); end
        end
        valid_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({b_we, b_ready, b_full, b_count} !== {1'b0, 1'b0, 1'b1, 3'd4})
                begin errors++; $display("FAIL full_block%0d got %b exp %b", i, {b_we, b_ready, b_full, b_count}, {1'b0, 1'b0, 1'b1, 3'd4}); end
        end
        valid_b = 1'b0;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        checks++;
        if ({b_count, b_full, b_ready, b_we} !== {3'd0, 1'b0, 1'b1, 1'b0})
            begin errors++; $display("FAIL full_rst got %b exp %b", {b_count, b_full, b_ready, b_we}, {3'd0, 1'b0, 1'b1, 1'b0}); end
        ack_b = 1'b0;
    endtask

    task automatic test_seal();
        do_reset();
        imem_ack = 1'b1;
`ifdef ENC_HALT_STUB_EN
        set_desc(0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
        end
        seal = 1'b1;
        tick();
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd2, 32'h08000002})
            begin errors++; $display("FAIL seal_stub got %h exp %h", {imem_we, imem_addr, imem_wdata}, {1'b1, 10'd2, 32'h08000002}); end
        tick();
        tick();
        checks++;
        if ({sealed, in_ready, imem_we, count} !== {1'b1, 1'b0, 1'b0, 11'd3})
            begin errors++; $display("FAIL seal_done got %b exp %b", {sealed, in_ready, imem_we, count}, {1'b1, 1'b0, 1'b0, 11'd3}); end
        do_reset();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (imem_wdata !== 32'h00221820) begin errors++; $display("FAIL seal_desc_wins got %h exp 00221820", imem_wdata); end
        tick();
        tick();
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd1, 32'h08000001})
            begin errors++; $display("FAIL seal_pending got %h exp %h", {imem_we, imem_addr, imem_wdata}, {1'b1, 10'd1, 32'h08000001}); end
        tick();
        checks++;
        if (sealed !== 1'b1) begin errors++; $display("FAIL seal_pending_done got %b exp 1", sealed); end
`else
        seal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({imem_we, sealed, in_ready} !== 3'b001)
                begin errors++; $display("FAIL seal_ignored%0d got %b exp 001", i, {imem_we, sealed, in_ready}); end
        end
`endif
        seal = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic test_rst_mid_wr();
        do_reset();
        imem_ack = 1'b0;
        set_desc(5, 5'd7, 5'd9, 5'd11, 16'd0, 26'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1) begin errors++; $display("FAIL midwr_we got %b exp 1", imem_we); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({imem_we, in_ready, count, imem_wdata} !== {1'b0, 1'b1, 11'd0, 32'd0})
            begin errors++; $display("FAIL midwr_rst got %h exp %h", {imem_we, in_ready, count, imem_wdata}, {1'b0, 1'b1, 11'd0, 32'd0}); end
        tick();
        checks++;
        if (imem_we !== 1'b0) begin errors++; $display("FAIL midwr_drop got %b exp 0", imem_we); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_two_words();
        test_ack_delay();
        test_invalid();
        test_random();
        test_full();
        test_seal();
        test_rst_mid_wr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Instruction encoder and instruction-memory writer for the MIPS32 SOC, working in the opposite direction from the control-unit decoder. It accepts symbolic instruction descriptors (operation kind plus register, immediate and target fields) over a valid/ready handshake. Each descriptor is packed into a 32-bit MIPS word and written sequentially into instruction memory through a req/ack write port. The block serves as the on-chip program loader and self-test program generator feeding the decoder's opcode/func space.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width
- BASE_ADDR, 0, word address of the first written instruction; used for J self-targets

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  descriptor valid
- in_ready  out  1  block can accept a descriptor
- in_kind  in  5  operation: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 SLT, 7 ADDI, 8 ADDIU, 9 ANDI, 10 ORI, 11 LUI, 12 BEQ, 13 BNE, 14 LW, 15 SW, 16 J; 17–31 invalid
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate or branch word offset, used verbatim
- in_target  in  26  J target field
- seal  in  1  level request to append a halt stub (see Configuration)
- imem_we  out  1  write request, held until ack
- imem_ack  in  1  write accepted this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- count  out  ADDR_W+1  number of words written
- inv_op  out  1  one-cycle pulse: invalid kind consumed
- full  out  1  address space exhausted
- sealed  out  1  halt stub written

## Operation
- Encoding:
  - R-type: {6'h00, rs, rt, rd, 5'd0, func}. func values: ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, SLT 2A (hex).
  - I-type: {op, rs, rt, imm}. op values: ADDI 08, ADDIU 09, ANDI 0C, ORI 0D, LUI 0F, BEQ 04, BNE 05, LW 23, SW 2B (hex).
  - LUI forces rs=0.
  - J: {6'h02, target}.
- FSM states: IDLE, WR, FULL, DONE.
  - IDLE: in_ready=1. On in_valid:
    - Valid kind: register the encoded word, go to WR.
    - Invalid kind: consume the descriptor, pulse inv_op next cycle, stay in IDLE, no write.
  - WR: imem_we=1; addr and data are stable. On imem_ack: increment count and addr.
    - If count reaches 2^ADDR_W, go to FULL; otherwise go to IDLE.
    - If the write was the halt stub, go to DONE.
  - FULL: in_ready=0, full=1. Seal is ignored. Exit only by rst.
  - DONE: in_ready=0, sealed=1. Exit only by rst.
- Addresses never wrap. imem_addr = count[ADDR_W-1:0].
- rst in any state, including mid-WR: the pending word is dropped and imem_we=0 the following cycle.

## Timing
- Values after reset: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, count=0, inv_op=0, full=0, sealed=0.
- in_ready is decoded from state only. It has no combinational path from in_valid or seal.
- Latency: descriptor accepted in cycle N → imem_we high in cycle N+1.
- Ack in the same cycle as we → in_ready high in N+2. Peak throughput is one word per 2 cycles.
- imem_we, imem_addr and imem_wdata are held unchanged until the cycle with imem_ack=1. count updates on the cycle after ack.
- in_valid is sampled only in IDLE; the descriptor must stay stable while in_valid=1 and in_ready=0.
- in_valid and seal both high in IDLE: the descriptor wins. Seal stays pending because it is level-sensitive.

## Configuration
- ENC_HALT_STUB_EN defined:
  - In IDLE with seal=1, in_valid=0 and not full, the block writes J to its own address: target = BASE_ADDR + count, zero-extended to 26 bits.
  - After the ack it enters DONE.
- Undefined: seal is ignored, sealed is tied to 0, and DONE is unreachable.

## Structure
- Shared package mips_enc_pkg holds:
  - the in_kind enumeration;
  - opcode and funct constants, taken from the same values as opcodes.vh so the encoder and decoder cannot diverge;
  - the FSM state type.
- Sub-module mips_field_packer: purely combinational kind + fields → {word, kind_valid}. The top level holds the FSM, counters and handshake.

## Test plan
- ADD rs=1 rt=2 rd=3, ack in the same cycle as we → imem_wdata=0x00221820 at addr 0, count=1, in_ready high 2 cycles after acceptance.
- ADDI rt=8 imm=5, then LW rs=29 rt=4 imm=0xFFFC → 0x20080005 at addr 0, then 0x8FA4FFFC at addr 1.
- ack delayed 3 cycles → we, addr and data stable for 4 cycles, in_ready=0 throughout, count increments only after ack.
- in_kind=31 → inv_op pulse of exactly 1 cycle, no imem_we, count unchanged, next valid ADD written at addr 0.
- ADDR_W=2, four writes → full=1, in_ready=0; a fifth in_valid is never accepted; rst returns count to 0.
- ENC_HALT_STUB_EN, BASE_ADDR=0, two writes then seal → 0x08000002 at addr 2, sealed=1. Also assert rst mid-WR: imem_we=0 next cycle.
